// File: rtl/mac_ctrl_pkg.sv
// mac_ctrl_pkg: shared state encoding and sizing constants for the MAC pipeline controller.
package mac_ctrl_pkg;
    localparam int LEN_W_DEF      = 12;
    localparam int MAC_PIPE_DEPTH = 5;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_e;
endpackage

// File: rtl/mac_pipe_ctrl_beat_counter.sv
// beat_counter: up-counter with synchronous clear and increment enable.
module beat_counter #(
    parameter int W = 12
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_clr,
    input  logic         i_inc,
    output logic [W-1:0] o_cnt
);
    logic [W-1:0] cnt_d, cnt_q;

    always_comb cnt_d = i_clr ? '0 : i_inc ? cnt_q + W'(1) : cnt_q;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) cnt_q <= '0;
        else          cnt_q <= cnt_d;
    end

    assign o_cnt = cnt_q;
endmodule

// File: rtl/mac_pipe_ctrl.sv
// mac_pipe_ctrl: job sequencer for the 5-stage MAC pipeline; admits beats, drives the
// global stall, retires results under valid/ready and pulses done at job end.
module mac_pipe_ctrl
    import mac_ctrl_pkg::*;
#(
    parameter int LEN_W      = LEN_W_DEF,
    parameter int PIPE_DEPTH = MAC_PIPE_DEPTH
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_start,
    input  logic [LEN_W-1:0] i_len,
    input  logic             i_in_valid,
    output logic             o_in_ready,
    output logic             o_pipe_valid,
    output logic             o_inhibit,
    input  logic             i_pipe_valid,
    output logic             o_out_valid,
    input  logic             i_out_ready,
    output logic             o_last,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_err,
    output logic [50:0]      o_transistor_num
);
    state_e state_d, state_q;
    logic [LEN_W-1:0] len_d, len_q, issue_cnt, retire_cnt, in_flight;
    logic err_d, err_q;
    logic start_acc, retire, last_issue, last_retire;

    beat_counter #(.W(LEN_W)) u_issue (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_clr(start_acc), .i_inc(o_pipe_valid), .o_cnt(issue_cnt)
    );

    beat_counter #(.W(LEN_W)) u_retire (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_clr(start_acc), .i_inc(retire), .o_cnt(retire_cnt)
    );

    always_comb begin
        start_acc    = i_start & (state_q == IDLE);
        o_inhibit    = i_pipe_valid & ~i_out_ready;
        o_out_valid  = i_pipe_valid & ((state_q == RUN) | (state_q == DRAIN));
        o_in_ready   = (state_q == RUN) & ~o_inhibit & (issue_cnt != len_q);
        o_pipe_valid = i_in_valid & o_in_ready;
        o_last       = o_out_valid & (retire_cnt == len_q - LEN_W'(1));
        o_busy       = state_q != IDLE;
        o_done       = state_q == DONE;
        o_err        = err_q;
        retire       = o_out_valid & i_out_ready;
        last_issue   = o_pipe_valid & (issue_cnt == len_q - LEN_W'(1));
        last_retire  = o_last & i_out_ready;
        in_flight    = issue_cnt - retire_cnt;
        len_d        = start_acc ? i_len : len_q;
        // results outside a job are dropped, but still flagged as a protocol error
        err_d        = (err_q & ~start_acc)
                     | (i_pipe_valid & ((state_q == IDLE) | (state_q == DONE)))
                     | (retire & (retire_cnt == issue_cnt))
                     | (in_flight > LEN_W'(PIPE_DEPTH));
        state_d      = state_q == IDLE  ? (start_acc ? ((i_len != '0) ? RUN : DONE) : IDLE)
                     : state_q == RUN   ? (last_issue ? (last_retire ? DONE : DRAIN) : RUN)
                     : state_q == DRAIN ? (last_retire ? DONE : DRAIN)
                     : IDLE;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
            len_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            err_q   <= err_d;
        end
    end

    assign o_transistor_num = '0;
endmodule

// File: tb/tb_mac_pipe_ctrl.sv
// tb_mac_pipe_ctrl: drives jobs through the controller with a behavioural MAC pipe and
// checks retired results against a job-level scoreboard.
module tb_mac_pipe_ctrl;
    localparam int LEN_W = 12;
    localparam int DEPTH = 5;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic [LEN_W-1:0] len = '0;
    logic in_valid = 1'b0;
    logic out_ready = 1'b1;
    logic force_pv = 1'b0;
    logic [15:0] in_data = '0;
    logic in_ready, pipe_valid_o, inhibit, out_valid, last, busy, done, err;
    logic [50:0] tnum;
    logic pv[DEPTH];
    logic [15:0] pd[DEPTH];
    logic pipe_valid_i;

    typedef struct {logic [15:0] d; logic l;} exp_t;
    exp_t exp_q[$];
    exp_t e;

    int total = 0, bad = 0;
    int cyc = 0, start_cyc = 0, done_cyc = 0, done_cnt = 0, exp_done = 0;
    int issued = 0, retired = 0, cur_len = 0, inhib_cnt = 0, pv_cnt = 0, ov_cnt = 0;
    bit job_active = 0, done_seen = 0, in_job = 0, exp_err = 0;

    always #5 clk = ~clk;

    assign pipe_valid_i = pv[DEPTH-1] | force_pv;

    mac_pipe_ctrl dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_len(len),
        .i_in_valid(in_valid), .o_in_ready(in_ready), .o_pipe_valid(pipe_valid_o),
        .o_inhibit(inhibit), .i_pipe_valid(pipe_valid_i), .o_out_valid(out_valid),
        .i_out_ready(out_ready), .o_last(last), .o_busy(busy), .o_done(done),
        .o_err(err), .o_transistor_num(tnum)
    );

    // behavioural MAC pipe: fixed depth, every stage holds while inhibited
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < DEPTH; k++) begin
                pv[k] <= 1'b0;
                pd[k] <= '0;
            end
        end else if (!inhibit) begin
            pv[0] <= pipe_valid_o;
            pd[0] <= in_data;
            for (int k = 1; k < DEPTH; k++) begin
                pv[k] <= pv[k-1];
                pd[k] <= pd[k-1];
            end
        end
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            in_job = job_active && (cyc != start_cyc);
            chk("inhibit", inhibit, pipe_valid_i & ~out_ready);
            chk("out_valid", out_valid, pipe_valid_i & in_job);
            chk("in_ready", in_ready, in_job && (issued < cur_len) && !(pipe_valid_i && !out_ready));
            chk("pipe_valid", pipe_valid_o, in_valid & in_ready);
            chk("busy", busy, in_job);
            chk("last", last, out_valid && (exp_q.size() > 0) && exp_q[0].l);
            chk("err", err, exp_err);
            exp_err = (exp_err && !(start && !in_job)) || (pipe_valid_i && !in_job);
            if (inhibit) inhib_cnt++;
            if (pipe_valid_o) pv_cnt++;
            if (out_valid) ov_cnt++;
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) chk("retire_unexpected", 1, 0);
                else begin
                    e = exp_q.pop_front();
                    chk("data", pd[DEPTH-1], e.d);
                    chk("last_at_retire", last, e.l);
                end
                retired++;
            end
            if (pipe_valid_o) begin
                exp_q.push_back('{d: in_data, l: (issued == cur_len - 1)});
                issued++;
            end
            if (done) begin
                done_seen  = 1;
                done_cyc   = cyc;
                done_cnt++;
                job_active = 0;
            end
        end
    end

    task automatic drive(input int rel, input int mode);
        in_data = 16'($urandom);
        start = 1'b0;
        case (mode)
            0: begin in_valid = 1'b1; out_ready = 1'b1; end
            1: begin in_valid = 1'b1; out_ready = !(rel >= 7 && rel <= 10); end
            2: begin
                in_valid  = (rel > 5) || (rel % 2 == 1);
                out_ready = 1'b1;
                if (rel == 3) begin start = 1'b1; len = 12'd7; end
            end
            default: begin
                in_valid  = $urandom_range(0, 9) < 7;
                out_ready = $urandom_range(0, 9) < 6;
            end
        endcase
    endtask

    task automatic run_job(input int l, input int mode, input int exp_rel, input int abort_rel);
        @(posedge clk);
        #1;
        drive(0, mode);
        start = 1'b1;
        len = LEN_W'(l);
        cur_len = l;
        issued = 0; retired = 0; inhib_cnt = 0; pv_cnt = 0; ov_cnt = 0;
        done_seen = 0;
        start_cyc = cyc;
        job_active = 1;
        exp_done++;
        for (int i = 0; i < 600 && !done_seen; i++) begin
            @(posedge clk);
            if (!done_seen) begin
                #1;
                if (cyc - start_cyc == abort_rel) begin
                    rst_n = 1'b0;
                    #1;
                    chk("reset_outputs", {in_ready, pipe_valid_o, inhibit, out_valid, last, busy, done, err}, 0);
                    exp_q.delete();
                    job_active = 0;
                    exp_err = 0;
                    exp_done--;
                    in_valid = 1'b0;
                    @(posedge clk);
                    #3 rst_n = 1'b1;
                    return;
                end
                drive(cyc - start_cyc, mode);
            end
        end
        chk("done_seen", done_seen, 1);
        if (!done_seen) begin
            rst_n = 1'b0;
            exp_q.delete();
            job_active = 0;
            exp_err = 0;
            exp_done--;
            #3 rst_n = 1'b1;
            return;
        end
        if (exp_rel >= 0) chk("done_latency", done_cyc - start_cyc, exp_rel);
        chk("retired_count", retired, l);
        chk("queue_empty", exp_q.size(), 0);
        @(posedge clk);
        #1;
        start = 1'b0;
        @(negedge clk);
        chk("done_pulses", done_cnt, exp_done);
    endtask

    initial begin
        #2;
        chk("reset_state", {in_ready, pipe_valid_o, inhibit, out_valid, last, busy, done, err}, 0);
        chk("transistor_num", tnum, 0);
        #21 rst_n = 1'b1;

        run_job(4, 0, 10, -1);
        chk("t1_issued", pv_cnt, 4);
        chk("t1_results", ov_cnt, 4);

        run_job(8, 1, 18, -1);
        chk("t2_inhibit_cycles", inhib_cnt, 4);

        run_job(0, 0, 1, -1);
        chk("t3_no_issue", pv_cnt, 0);
        chk("t3_no_result", ov_cnt, 0);

        run_job(3, 2, 11, -1);

        @(posedge clk);
        #1 out_ready = 1'b1; force_pv = 1'b1;
        @(posedge clk);
        #1 force_pv = 1'b0;
        chk("t5_err_set", err, 1);
        @(posedge clk);
        #1 chk("t5_err_sticky", err, 1);
        run_job(2, 0, -1, -1);
        chk("t5_err_cleared", err, 0);

        run_job(4, 0, -1, 7);
        run_job(2, 0, 8, -1);

        for (int j = 0; j < 12; j++) run_job($urandom_range(0, 20), 3, -1, -1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
